// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_fifo                                                  |
// | Description : Single-clock FIFO with occupancy counter, almost-full and  |
// |               almost-empty flags, a choice of registered or first-word-  |
// |               fall-through read, and optional sticky overflow/underflow  |
// |               flags.                                                     |
// | Options     : SYNC_FIFO_ERR_FLAG_EN - when defined, o_ovf/o_udf are live |
// |               sticky flags cleared by i_err_clr; otherwise both are tied |
// |               to 0 and i_err_clr is ignored.                             |
// | Ports       : i_clk      rising-edge clock                               |
// |               i_rst_n    asynchronous active-low reset                   |
// |               i_wdata    write data (WIDTH)                              |
// |               i_push     write request                                   |
// |               i_pop      read request                                    |
// |               i_err_clr  clears sticky error flags                       |
// |               o_rdata    read data (WIDTH)                               |
// |               o_full / o_empty / o_afull / o_aempty  status flags        |
// |               o_count    occupancy (AW+1)                                |
// |               o_ovf / o_udf  sticky overflow / underflow                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 1,
   parameter int FWFT      = 0,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_err_clr,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_afull,
   output logic             o_aempty,
   output logic [AW:0]      o_count,
   output logic             o_ovf,
   output logic             o_udf
);

   localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_afull_th  = (AW+1)'(AFULL_TH);
   localparam logic [AW:0]   c_aempty_th = (AW+1)'(AEMPTY_TH);
   localparam logic [AW-1:0] c_last      = AW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_empty;
   logic w_push_ok;
   logic w_pop_ok;

   // Status is decoded from the registered count only, so no input reaches
   // an output combinationally.
   assign w_full    = (r_count == c_depth);
   assign w_empty   = (r_count == '0);
   assign w_push_ok = i_push & ~w_full;
   assign w_pop_ok  = i_pop & ~w_empty;

   assign o_full   = w_full;
   assign o_empty  = w_empty;
   assign o_afull  = (r_count >= c_afull_th);
   assign o_aempty = (r_count <= c_aempty_th);
   assign o_count  = r_count;

   // Storage carries no reset; emptiness is tracked by the count alone.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Explicit wrap keeps non-power-of-two depths correct.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   generate
      if (FWFT == 0) begin : g_reg_rd
         logic [WIDTH-1:0] r_rdata;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_rdata <= '0;
            end else if (w_pop_ok) begin
               r_rdata <= r_mem[r_rptr];
            end
         end

         assign o_rdata = r_rdata;
      end else begin : g_fwft_rd
         // Head word is shown directly; forced to zero while empty so the
         // output is clean out of reset even though storage is not.
         assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
      end
   endgenerate

`ifdef SYNC_FIFO_ERR_FLAG_EN
   logic r_ovf;
   logic r_udf;

   // Setting takes priority over clearing in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (i_push && w_full) begin
            r_ovf <= 1'b1;
         end else if (i_err_clr) begin
            r_ovf <= 1'b0;
         end
         if (i_pop && w_empty) begin
            r_udf <= 1'b1;
         end else if (i_err_clr) begin
            r_udf <= 1'b0;
         end
      end
   end

   assign o_ovf = r_ovf;
   assign o_udf = r_udf;
`else
   logic w_unused_err_clr;

   assign w_unused_err_clr = i_err_clr;
   assign o_ovf            = 1'b0;
   assign o_udf            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_sync_fifo                                               |
// | Description : Scoreboard bench for sync_fifo. Three instances: DEPTH=8   |
// |               registered read, DEPTH=5 registered read, DEPTH=8 FWFT.    |
// |               Read data of the registered instances is checked by        |
// |               monitor processes against expected-word queues.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_FLAG_EN
   localparam bit c_err_en = 1'b1;
`else
   localparam bit c_err_en = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   // ---------------- instance A: DEPTH 8, registered read ----------------
   logic [15:0] a_wdata = '0, a_rdata;
   logic        a_push = 0, a_pop = 0, a_clr = 0;
   logic        a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
   logic [3:0]  a_count;

   sync_fifo #(.WIDTH(16), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(a_wdata), .i_push(a_push),
      .i_pop(a_pop), .i_err_clr(a_clr), .o_rdata(a_rdata), .o_full(a_full),
      .o_empty(a_empty), .o_afull(a_afull), .o_aempty(a_aempty),
      .o_count(a_count), .o_ovf(a_ovf), .o_udf(a_udf));

   // ---------------- instance B: DEPTH 5, registered read ----------------
   logic [15:0] b_wdata = '0, b_rdata;
   logic        b_push = 0, b_pop = 0;
   logic        b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
   logic [3:0]  b_count;

   sync_fifo #(.WIDTH(16), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .FWFT(0)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(b_wdata), .i_push(b_push),
      .i_pop(b_pop), .i_err_clr(1'b0), .o_rdata(b_rdata), .o_full(b_full),
      .o_empty(b_empty), .o_afull(b_afull), .o_aempty(b_aempty),
      .o_count(b_count), .o_ovf(b_ovf), .o_udf(b_udf));

   // ---------------- instance C: DEPTH 8, FWFT ----------------
   logic [15:0] c_wdata = '0, c_rdata;
   logic        c_push = 0, c_pop = 0;
   logic        c_full, c_empty, c_afull, c_aempty, c_ovf, c_udf;
   logic [3:0]  c_count;

   sync_fifo #(.WIDTH(16), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_wdata(c_wdata), .i_push(c_push),
      .i_pop(c_pop), .i_err_clr(1'b0), .o_rdata(c_rdata), .o_full(c_full),
      .o_empty(c_empty), .o_afull(c_afull), .o_aempty(c_aempty),
      .o_count(c_count), .o_ovf(c_ovf), .o_udf(c_udf));

   // Reference contents and expected read-data queues
   logic [15:0] ma[$], qa[$], mb[$], qb[$];
   bit          m_ovf = 0, m_udf = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
   endtask

   task automatic a_cyc(input bit push, input bit pop, input bit clr, input logic [15:0] d);
      bit was_full, was_empty;
      was_full  = (ma.size() == 8);
      was_empty = (ma.size() == 0);
      a_push = push; a_pop = pop; a_clr = clr; a_wdata = d;
      if (pop && !was_empty) qa.push_back(ma.pop_front());
      if (push && !was_full) ma.push_back(d);
      if (push && was_full) m_ovf = 1; else if (clr) m_ovf = 0;
      if (pop && was_empty) m_udf = 1; else if (clr) m_udf = 0;
      @(posedge clk); #1;
      a_push = 0; a_pop = 0; a_clr = 0;
   endtask

   task automatic b_cyc(input bit push, input bit pop, input logic [15:0] d);
      bit was_full, was_empty;
      was_full  = (mb.size() == 5);
      was_empty = (mb.size() == 0);
      b_push = push; b_pop = pop; b_wdata = d;
      if (pop && !was_empty) qb.push_back(mb.pop_front());
      if (push && !was_full) mb.push_back(d);
      @(posedge clk); #1;
      b_push = 0; b_pop = 0;
   endtask

   task automatic c_cyc(input bit push, input bit pop, input logic [15:0] d);
      c_push = push; c_pop = pop; c_wdata = d;
      @(posedge clk); #1;
      c_push = 0; c_pop = 0;
   endtask

   // Monitors: an accepted pop presents its word one cycle later
   always @(posedge clk) begin
      if (rst_n && a_pop && !a_empty) begin
         #1;
         if (qa.size() == 0) begin
            n_tot++;
            $display("FAIL a_rdata: actual 0x%0h required no pop accepted", a_rdata);
         end else chk("a_rdata", a_rdata, qa.pop_front());
      end
   end

   always @(posedge clk) begin
      if (rst_n && b_pop && !b_empty) begin
         #1;
         if (qb.size() == 0) begin
            n_tot++;
            $display("FAIL b_rdata: actual 0x%0h required no pop accepted", b_rdata);
         end else chk("b_rdata", b_rdata, qb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset values ----
      #2;
      chk("rst_count", a_count, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full",  a_full, 0);
      chk("rst_aempty", a_aempty, 1);
      chk("rst_afull", a_afull, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_ovf", a_ovf, 0);
      chk("rst_udf", a_udf, 0);
      chk("rst_c_rdata", c_rdata, 0);
      #10 rst_n = 1;
      @(posedge clk); #1;

      // ---- A: fill 0x0001..0x0008 ----
      for (int i = 1; i <= 8; i++) begin
         a_cyc(1, 0, 0, 16'(i));
         chk("fill_count", a_count, i);
         if (i == 5) chk("afull_at5", a_afull, 0);
         if (i == 6) chk("afull_at6", a_afull, 1);
         if (i == 2) chk("aempty_at2", a_aempty, 0);
      end
      chk("full", a_full, 1);

      // ---- A: push+pop while full: pop wins, 0xDEAD dropped ----
      a_cyc(1, 1, 0, 16'hDEAD);
      chk("fullpp_count", a_count, 7);
      chk("fullpp_full", a_full, 0);
      chk("fullpp_ovf", a_ovf, c_err_en ? 1 : 0);

      // ---- A: drain remaining 7 (monitor expects 0x0002..0x0008) ----
      for (int i = 0; i < 7; i++) a_cyc(0, 1, 0, 16'h0);
      chk("drain_empty", a_empty, 1);
      chk("drain_count", a_count, 0);
      chk("drain_rdata", a_rdata, 16'h0008);

      // ---- A: push+pop while empty: push wins, rdata holds ----
      a_cyc(1, 1, 0, 16'hBEEF);
      chk("emptypp_count", a_count, 1);
      chk("emptypp_rdata", a_rdata, 16'h0008);
      chk("emptypp_udf", a_udf, c_err_en ? 1 : 0);
      chk("ovf_held", a_ovf, c_err_en ? 1 : 0);
      a_cyc(0, 0, 1, 16'h0);
      chk("clr_ovf", a_ovf, 0);
      chk("clr_udf", a_udf, 0);
      a_cyc(0, 1, 0, 16'h0);
      chk("beef_empty", a_empty, 1);

      // ---- A: error flags ----
      for (int i = 0; i < 8; i++) a_cyc(1, 0, 0, 16'h0010 + 16'(i));
      a_cyc(1, 0, 0, 16'hFFFF);
      chk("ovf_set", a_ovf, c_err_en ? 1 : 0);
      chk("ovf_count", a_count, 8);
      a_cyc(0, 0, 0, 16'h0);
      chk("ovf_hold", a_ovf, c_err_en ? 1 : 0);
      for (int i = 0; i < 8; i++) a_cyc(0, 1, 0, 16'h0);
      a_cyc(0, 1, 0, 16'h0);
      chk("udf_set", a_udf, c_err_en ? 1 : 0);
      chk("udf_count", a_count, 0);
      a_cyc(0, 1, 1, 16'h0);
      chk("udf_set_wins", a_udf, c_err_en ? 1 : 0);
      chk("ovf_cleared", a_ovf, 0);
      a_cyc(0, 0, 1, 16'h0);
      chk("udf_cleared", a_udf, 0);

      // ---- B: DEPTH 5, three rounds across pointer wrap ----
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) begin
            b_cyc(1, 0, 16'h0100 * 16'(r + 1) + 16'(i));
            chk("b_fill_count", b_count, i + 1);
         end
         chk("b_full", b_full, 1);
         for (int i = 0; i < 5; i++) begin
            b_cyc(0, 1, 16'h0);
            chk("b_drain_count", b_count, 4 - i);
         end
         chk("b_empty", b_empty, 1);
      end

      // ---- C: FWFT head visible without pop ----
      c_cyc(1, 0, 16'hA5A5);
      chk("fwft_rdata", c_rdata, 16'hA5A5);
      chk("fwft_nempty", c_empty, 0);
      c_cyc(0, 0, 16'h0);
      chk("fwft_hold", c_rdata, 16'hA5A5);
      c_cyc(1, 0, 16'h5A5A);
      chk("fwft_head", c_rdata, 16'hA5A5);
      chk("fwft_count", c_count, 2);
      c_cyc(0, 1, 16'h0);
      chk("fwft_next", c_rdata, 16'h5A5A);
      c_cyc(0, 1, 16'h0);
      chk("fwft_empty", c_empty, 1);

      // ---- A: asynchronous reset with 4 words stored ----
      for (int i = 0; i < 4; i++) a_cyc(1, 0, 0, 16'h0040 + 16'(i));
      chk("pre_rst_count", a_count, 4);
      #3 rst_n = 0;
      ma.delete(); m_ovf = 0; m_udf = 0;
      #1;
      chk("arst_count", a_count, 0);
      chk("arst_empty", a_empty, 1);
      #2 rst_n = 1;
      @(posedge clk); #1;
      a_cyc(1, 0, 0, 16'h1234);
      a_cyc(0, 1, 0, 16'h0);
      chk("post_rst_rdata", a_rdata, 16'h1234);
      chk("post_rst_empty", a_empty, 1);

      @(posedge clk); #2;
      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock i_clk, reset i_rst_n; all state SHALL clear on i_rst_n low, independent of i_clk.
REQ-002 Parameter WIDTH, default 16, data word width in bits (>=1).
REQ-003 Parameter DEPTH, default 8, storage entries (>=2, any integer, power of two not required).
REQ-004 Parameter AFULL_TH, default 6, almost-full threshold in entries (1..DEPTH).
REQ-005 Parameter AEMPTY_TH, default 1, almost-empty threshold in entries (0..DEPTH-1).
REQ-006 Parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-007 i_clk  input  1  clock, rising edge.
REQ-008 i_rst_n  input  1  asynchronous active-low reset.
REQ-009 i_wdata  input  WIDTH  write data.
REQ-010 i_push  input  1  write request.
REQ-011 i_pop  input  1  read request.
REQ-012 i_err_clr  input  1  clears sticky error flags.
REQ-013 o_rdata  output  WIDTH  read data.
REQ-014 o_full / o_empty  output  1 each  FIFO full / empty.
REQ-015 o_afull / o_aempty  output  1 each  almost-full / almost-empty.
REQ-016 o_count  output  AW+1  occupancy, AW = ceil(log2(DEPTH)), minimum 1.
REQ-017 o_ovf / o_udf  output  1 each  sticky overflow / underflow.

Function
REQ-018 Push SHALL be accepted iff i_push && !o_full; accepted word SHALL be written at wptr and wptr SHALL advance.
REQ-019 Pop SHALL be accepted iff i_pop && !o_empty; rptr SHALL advance.
REQ-020 Both pointers SHALL be AW bits and wrap from DEPTH-1 to 0.
REQ-021 o_count SHALL be registered: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-022 o_full = (o_count == DEPTH); o_empty = (o_count == 0); o_afull = (o_count >= AFULL_TH); o_aempty = (o_count <= AEMPTY_TH); all decoded from registered state only, with no input-to-output combinational path.
REQ-023 Simultaneous push+pop when full: pop accepted, push rejected, count goes DEPTH-1.
REQ-024 Simultaneous push+pop when empty: push accepted, pop rejected, count goes 1.
REQ-025 Simultaneous push+pop otherwise: both accepted, count unchanged.
REQ-026 FWFT=0: on accepted pop, o_rdata SHALL load mem[rptr] at that edge (1-cycle latency) and SHALL hold otherwise.
REQ-027 FWFT=1: o_rdata SHALL equal mem[rptr] whenever !o_empty (head visible with zero latency); accepted pop exposes the next word the following cycle; o_rdata is don't-care when empty.
REQ-028 Order SHALL be strict FIFO; no word lost or duplicated across pointer wrap.
REQ-029 Rejected push/pop SHALL not alter memory, pointers, or count.

Reset
REQ-030 On i_rst_n low: wptr=0, rptr=0, o_count=0, o_empty=1, o_full=0, o_aempty=1, o_afull=(AFULL_TH==0 ? 1 : 0), o_rdata=0, o_ovf=0, o_udf=0.
REQ-031 Memory contents SHALL not be reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored words immediately; the first push after release SHALL be the first word read.

Configuration
REQ-033 Macro SYNC_FIFO_ERR_FLAG_EN defined: o_ovf SHALL set on i_push while o_full, o_udf SHALL set on i_pop while o_empty; both SHALL stay set until i_err_clr=1 for one cycle (set wins over clear in the same cycle).
REQ-034 Macro SYNC_FIFO_ERR_FLAG_EN undefined: o_ovf and o_udf SHALL be constant 0, i_err_clr SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-035 DEPTH=8, FWFT=0: push 0x0001..0x0008 -> o_full=1, o_count=8, o_afull=1 from count 6; pop 8 -> o_rdata 0x0001..0x0008, each one cycle after its pop; o_empty=1.
REQ-036 DEPTH=5 (non-power-of-two): 3 rounds of push 5 / pop 5 -> data in order across wrap, o_count sequence 0..5..0.
REQ-037 Full with push+pop -> count 8->7, push data dropped; empty with push+pop -> count 0->1, o_rdata unchanged (FWFT=0).
REQ-038 FWFT=1: push 0xA5A5 into empty -> o_rdata=0xA5A5 next cycle with no pop; pop -> o_empty=1.
REQ-039 SYNC_FIFO_ERR_FLAG_EN defined: push when full -> o_ovf=1 held; pop when empty -> o_udf=1; i_err_clr pulse -> both 0. Undefined: same stimulus -> both stay 0.
REQ-040 Reset pulse with count=4 -> o_count=0, o_empty=1 asynchronously; next push 0x1234 then pop -> o_rdata=0x1234.
